// File: rtl/prbs3_checker.sv
// PRBS3 (x^3+x^2+1) stream checker: hunt/verify/lock with error pulse and saturating count.
// err lags the mismatching bit by one edge; din_vld=0 freezes everything and there is no backpressure.
module prbs3_checker #(
  parameter int LOCK_CHK = 4,
  parameter int LOSS_N   = 3,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             din,
  input  logic             din_vld,
  input  logic             err_clr,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MW = $clog2(LOCK_CHK + 1);
  localparam int LW = $clog2(LOSS_N + 1);
  localparam logic [MW-1:0] MATCH_DONE = MW'(LOCK_CHK);
  localparam logic [LW-1:0] LOSS_DONE  = LW'(LOSS_N);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [3:1]       sr, sr_nxt;
  logic [1:0]       fill, fill_nxt;
  logic [MW-1:0]    match, match_nxt, match_inc;
  logic [LW-1:0]    miss, miss_nxt, miss_inc;
  logic             locked_nxt, err_nxt, cnt_inc;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic             pred;
  logic [3:1]       sr_din;

  assign pred      = sr[1] ^ sr[3];
  assign sr_din    = {sr[2:1], din};
  assign match_inc = match + 1'b1;
  assign miss_inc  = miss + 1'b1;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state   <= HUNT;
      sr      <= 3'b000;
      fill    <= 2'd0;
      match   <= '0;
      miss    <= '0;
      locked  <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
    end else begin
      state   <= state_nxt;
      sr      <= sr_nxt;
      fill    <= fill_nxt;
      match   <= match_nxt;
      miss    <= miss_nxt;
      locked  <= locked_nxt;
      err     <= err_nxt;
      err_cnt <= err_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    fill_nxt  = fill;
    match_nxt = match;
    miss_nxt  = miss;
    err_nxt   = 1'b0;
    cnt_inc   = 1'b0;

    if (din_vld) begin
      case (state)
        HUNT: begin
          sr_nxt   = sr_din;
          fill_nxt = fill + 2'd1;
          if (fill == 2'd2) begin
            // an all-zero history would predict zeros forever, so never leave HUNT on it
            if (sr_din != 3'b000) begin
              state_nxt = VERIFY;
              match_nxt = '0;
            end else begin
              fill_nxt = 2'd0;
            end
          end
        end

        VERIFY: begin
          if (din == pred) begin
            sr_nxt    = sr_din;
            match_nxt = match_inc;
            if (match_inc == MATCH_DONE) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            state_nxt = HUNT;
            fill_nxt  = 2'd0;
          end
        end

        LOCKED: begin
          // free-running on the prediction so a single line error is counted once
          sr_nxt = {sr[2:1], pred};
          if (din != pred) begin
            err_nxt  = 1'b1;
            cnt_inc  = 1'b1;
            miss_nxt = miss_inc;
            if (miss_inc == LOSS_DONE) begin
              state_nxt = HUNT;
              fill_nxt  = 2'd0;
            end
          end else begin
            miss_nxt = '0;
          end
        end

        default: begin
          state_nxt = HUNT;
          fill_nxt  = 2'd0;
        end
      endcase
    end

    locked_nxt = (state_nxt == LOCKED);

    if (err_clr) begin
      err_cnt_nxt = '0;
    end else if (cnt_inc && !(&err_cnt)) begin
      err_cnt_nxt = err_cnt + 1'b1;
    end else begin
      err_cnt_nxt = err_cnt;
    end
  end

endmodule

// File: tb/tb_prbs3_checker.sv
// Directed bench for prbs3_checker: lock, single/burst errors, hold, reset, zero stream, saturation.
module tb_prbs3_checker;

  logic       clk = 1'b0;
  logic       clr_n;
  logic       din;
  logic       din_vld;
  logic       err_clr;
  logic       locked;
  logic       err;
  logic [7:0] err_cnt;

  int tests = 0;
  int fails = 0;
  int idx   = 0;
  logic err_seen;
  logic locked_seen;
  logic pat [0:6];

  prbs3_checker #(.LOCK_CHK(4), .LOSS_N(3), .CNT_W(8)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .din     (din),
    .din_vld (din_vld),
    .err_clr (err_clr),
    .locked  (locked),
    .err     (err),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // apply one cycle of inputs, then sample just after the rising edge
  task automatic step(input logic d, input logic v, input logic c);
    din     = d;
    din_vld = v;
    err_clr = c;
    @(posedge clk);
    #1;
    if (err)    err_seen    = 1'b1;
    if (locked) locked_seen = 1'b1;
    din_vld = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic good();
    step(pat[idx % 7], 1'b1, 1'b0);
    idx++;
  endtask

  task automatic bad();
    step(~pat[idx % 7], 1'b1, 1'b0);
    idx++;
  endtask

  initial begin
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0; pat[3] = 1'b1;
    pat[4] = 1'b0; pat[5] = 1'b0; pat[6] = 1'b1;
    clr_n = 1'b0; din = 1'b1; din_vld = 1'b1; err_clr = 1'b0;
    err_seen = 1'b0; locked_seen = 1'b0;

    // reset state, including edges with valid data while held in reset
    #2;
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", err_cnt, 0);
    repeat (8) begin
      din = ~din;
      @(posedge clk);
    end
    #1;
    chk("rst_hold_locked", locked, 0);
    clr_n = 1'b1;

    // continuous stream: lock on 7th valid bit, clean for 100 bits
    idx = 0; err_seen = 1'b0;
    repeat (6) good();
    chk("lock_bit6", locked, 0);
    good();
    chk("lock_bit7", locked, 1);
    repeat (93) good();
    chk("clean_err_seen", err_seen, 0);
    chk("clean_cnt", err_cnt, 0);
    chk("clean_locked", locked, 1);

    // single inverted bit
    bad();
    chk("single_err", err, 1);
    chk("single_cnt", err_cnt, 1);
    chk("single_locked", locked, 1);
    good();
    chk("single_err_gone", err, 0);
    repeat (5) good();
    chk("single_cnt_hold", err_cnt, 1);

    // burst of three inversions drops lock, then relock
    step(1'b0, 1'b0, 1'b1);
    chk("clr_cnt", err_cnt, 0);
    bad();
    bad();
    chk("burst2_locked", locked, 1);
    chk("burst2_err", err, 1);
    bad();
    chk("burst3_err", err, 1);
    chk("burst3_locked", locked, 0);
    chk("burst3_cnt", err_cnt, 3);
    repeat (6) good();
    chk("relock_bit6", locked, 0);
    good();
    chk("relock_bit7", locked, 1);
    chk("relock_cnt_kept", err_cnt, 3);

    // invalid cycles with wrong data change nothing
    err_seen = 1'b0;
    repeat (4) step(~pat[idx % 7], 1'b0, 1'b0);
    chk("hold_err_seen", err_seen, 0);
    chk("hold_locked", locked, 1);
    chk("hold_cnt", err_cnt, 3);
    good();
    chk("hold_resume_err", err, 0);

    // async reset while locked with err_cnt=5
    bad(); good(); bad(); good();
    chk("pre_rst_cnt", err_cnt, 5);
    @(posedge clk);
    #3;
    clr_n = 1'b0;
    #1;
    chk("async_locked", locked, 0);
    chk("async_cnt", err_cnt, 0);
    @(posedge clk);
    #1;
    clr_n = 1'b1;

    // all-zero stream never locks
    err_seen = 1'b0; locked_seen = 1'b0;
    repeat (20) step(1'b0, 1'b1, 1'b0);
    chk("zero_locked_seen", locked_seen, 0);
    chk("zero_err_seen", err_seen, 0);
    chk("zero_cnt", err_cnt, 0);

    // din_vld toggling every other cycle
    clr_n = 1'b0;
    #1;
    clr_n = 1'b1;
    idx = 3;
    repeat (6) begin
      good();
      step(~pat[idx % 7], 1'b0, 1'b0);
    end
    chk("toggle_bit6", locked, 0);
    good();
    chk("toggle_bit7", locked, 1);

    // 300 forced errors saturate the counter
    for (int r = 0; r < 100; r++) begin
      repeat (3) bad();
      repeat (7) good();
    end
    chk("sat_cnt", err_cnt, 255);
    chk("sat_locked", locked, 1);

    // clear wins over a simultaneous increment
    step(~pat[idx % 7], 1'b1, 1'b1);
    idx++;
    chk("clr_vs_inc_cnt", err_cnt, 0);
    chk("clr_vs_inc_err", err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL timeout tests=%0d", tests);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/prbs3_checker.md
PRBS3_CHECKER -- requirements
Module: prbs3_checker

Interface
REQ-001 Parameter: LOCK_CHK, default 4, number of consecutive correct predictions required before lock is declared.
REQ-002 Parameter: LOSS_N, default 3, number of consecutive mismatches while locked that forces loss of lock.
REQ-003 Parameter: CNT_W, default 8, width of the error counter.
REQ-004 Port: clk  input  1  the single clock; all state updates on the rising edge.
REQ-005 Port: clr_n  input  1  reset, asynchronous, active-low.
REQ-006 Port: din  input  1  received serial bit; the generator's q[3] stream.
REQ-007 Port: din_vld  input  1  din is sampled only when din_vld=1.
REQ-008 Port: err_clr  input  1  synchronous clear of err_cnt.
REQ-009 Port: locked  output  1  registered; 1 while the block is in LOCKED.
REQ-010 Port: err  output  1  registered one-cycle pulse, one per bit mismatch while LOCKED.
REQ-011 Port: err_cnt  output  CNT_W  registered saturating mismatch count.

Function
REQ-012 Checked sequence: s[n] = s[n-1] XOR s[n-3], period 7; from generator seed q=110 the stream is 1,1,0,1,0,0,1 and then repeats.
REQ-013 Internal 3-bit history sr: sr[1] is the newest bit and sr[3] the oldest; predicted bit p = sr[1] XOR sr[3].
REQ-014 When din_vld=0, sr, the state, and all counters SHALL hold, and err SHALL be 0.
REQ-015 Three states (HUNT, VERIFY, LOCKED) SHALL be used: HUNT loads history, VERIFY confirms the sequence, LOCKED tracks it.
REQ-016 HUNT: each valid din SHALL shift into sr and increment a fill counter (0..3).
REQ-017 HUNT, on the valid bit that makes fill=3: if sr is nonzero, go to VERIFY with match count 0; if sr=000, clear fill and stay in HUNT (all-zero lock-up is never accepted).
REQ-018 VERIFY, on each valid bit: din=p shifts din into sr and increments the match count; reaching LOCK_CHK moves to LOCKED.
REQ-019 VERIFY, on a valid bit with din!=p: return to HUNT with fill=0; err is not pulsed and err_cnt is not changed.
REQ-020 LOCKED: p (not din) SHALL be shifted into sr, so one line error causes exactly one mismatch.
REQ-021 LOCKED, on a valid bit with din!=p: pulse err on the next cycle, increment err_cnt (saturating at 2^CNT_W-1), and increment the miss counter.
REQ-022 LOCKED, on a valid bit with din=p: reset the miss counter to 0.
REQ-023 LOCKED: when the miss counter reaches LOSS_N, go to HUNT with fill=0 and deassert locked on that same edge; the err pulse for that final miss is still emitted.
REQ-024 locked SHALL assert on the edge that enters LOCKED.
REQ-025 Latency: err is asserted in the cycle following the edge that sampled the mismatching bit.
REQ-026 err_cnt is free of state: it is not cleared on loss of lock and is not cleared on re-lock.
REQ-027 err_clr=1 SHALL make err_cnt 0 on the next edge; err_clr wins over a simultaneous increment, giving err_cnt=0.

Reset
REQ-028 clr_n=0 SHALL immediately force state=HUNT, sr=000, fill, match and miss counters to 0, locked=0, err=0, and err_cnt=0, independent of clk.
REQ-029 Reset mid-operation SHALL discard any lock; after clr_n returns to 1, the checker rehunts from an empty history.
REQ-030 Release of clr_n takes effect on the first rising clk edge after deassertion; no bit is sampled while clr_n=0.

Verification
REQ-031 Continuous din_vld=1 with stream 1101001 repeating -> locked=1 after the 7th valid bit (3 fill + 4 verify); err never asserts; err_cnt=0 after 100 bits.
REQ-032 Locked, one bit inverted -> exactly one err pulse one cycle later; err_cnt=1; locked stays 1.
REQ-033 Locked, three consecutive bits inverted -> three err pulses; err_cnt=3; locked=0 after the third miss; the correct stream then re-locks after 7 more valid bits.
REQ-034 din=0 constant with din_vld=1 -> locked never asserts; err never asserts; err_cnt stays 0.
REQ-035 Sequence sent with din_vld toggling every other cycle -> lock after the 7th valid bit; in a separate saturation run, 300 forced errors give err_cnt=255; err_clr=1 on the same cycle as an increment gives err_cnt=0.
REQ-036 clr_n pulsed low while locked with err_cnt=5 -> locked=0 and err_cnt=0 immediately, without waiting for a clk edge.
